gate_stim_checker: RTL and testbench
====================================

// Module: gate_stim_checker
// PURPOSE
//  Self-checking stimulus/capture stage for the 2-input gate-bank block.
//  Drives a/b through the full truth table 00,01,10,11. Samples the seven gate
//  outputs after a settle window and compares them with internally computed
//  golden values. Reports a mismatch count, per-vector fail flags and a one-cycle
//  done pulse. Sits directly upstream (drives a,b) and downstream (consumes *_y)
//  of the gate bank.
// PARAMETERS
//  SETTLE_CYCLES  1       cycles a/b are held before sampling (legal >=1)
//  ERR_W          5       width of err_cnt (saturating)
//  CHECK_MASK     7'h7F   per-output compare enable, bit order as gate_y below
// PORTS
//  clk       in   1      single clock, rising edge
//  rst       in   1      synchronous, active-high reset
//  start     in   1      begin a run; sampled only in IDLE
//  gate_y    in   7      {and,or,not,nand,nor,xor,xnor}_y, [6]=and ... [0]=xnor
//  a_out     out  1      stimulus a to gate bank (registered)
//  b_out     out  1      stimulus b to gate bank (registered)
//  busy      out  1      high from first stimulus cycle until done
//  done      out  1      one-cycle pulse at end of run
//  pass      out  1      1 = last completed run had zero masked mismatches
//  err_cnt   out  ERR_W  mismatching output bits over last run, saturating
//  fail_vec  out  4      fail_vec[i]=1 if vector i ({a,b}=i) had any mismatch
// BEHAVIOUR
//  Reset: state=IDLE; a_out=b_out=0; busy=done=pass=0; err_cnt=0; fail_vec=0.
//  States: IDLE -> SETTLE -> CHECK -> (SETTLE | DONE) -> IDLE.
//  IDLE: at the edge with start=1: idx=0, {a_out,b_out}=2'b00, err_cnt=0,
//   fail_vec=0, pass=0, busy=1, settle counter=SETTLE_CYCLES, go SETTLE.
//  SETTLE: stays exactly SETTLE_CYCLES cycles, then CHECK.
//  CHECK (1 cycle): golden from idx: and=a&b, or=a|b, not=~a, nand, nor, xor, xnor.
//   mism = (gate_y ^ golden) & CHECK_MASK. err_cnt += popcount(mism), clamped
//   at 2^ERR_W-1 (never wraps). fail_vec[idx] = |mism.
//   If idx<3: idx++, {a_out,b_out}=idx+1, reload counter, go SETTLE.
//   If idx==3: go DONE; a_out/b_out hold 2'b11.
//  DONE (1 cycle): done=1, busy=0, pass=(final err_cnt==0); next edge -> IDLE.
//  Per vector: SETTLE_CYCLES+1 cycles; start edge to done-high = 4*(S+1) cycles.
//  pass, err_cnt, fail_vec hold after done until the next accepted start.
//  Any X/Z on gate_y is out of scope. a_out/b_out never X after reset.
//  start while busy or in DONE is ignored. start held high re-triggers from IDLE
//   only, so back-to-back runs are separated by the IDLE cycle.
//  rst mid-run: all outputs return to reset values at that edge. No done pulse.
//   The next start performs a full fresh run.
//  rst and start in the same cycle: rst wins.
// TESTING
//  T1 rst for 2 cycles -> a_out=b_out=busy=done=pass=0, err_cnt=0, fail_vec=0.
//  T2 golden gate bank, S=1, start pulse at edge 0 -> {a,b}=00,01,10,11, each 2
//     cycles; busy high cycles 1..8; done single pulse at cycle 9; pass=1,
//     err_cnt=0, fail_vec=4'b0000.
//  T3 and_y stuck-at-0 -> err_cnt=1, fail_vec=4'b1000, pass=0.
//     Repeat with CHECK_MASK=7'h3F -> pass=1, err_cnt=0.
//  T4 xor_y replaced by xnor value -> err_cnt=4, fail_vec=4'b1111, pass=0.
//  T5 ERR_W=3, all seven outputs inverted -> 28 raw mismatches; err_cnt saturates
//     at 7, never wraps; fail_vec=4'b1111.
//  T6 start held high through run, then rst at cycle 5 -> reset values next edge,
//     no done. Release rst, pulse start -> full run, done after 8 cycles, pass=1.

Source files
------------

// File: rtl/gate_stim_checker.sv
// Stimulus/capture stage for the 2-input gate bank: walks {a,b} through 00..11,
// compares the seven gate outputs against golden values and reports the results.
module gate_stim_checker #(
    parameter int unsigned SETTLE_CYCLES = 1,
    parameter int unsigned ERR_W         = 5,
    parameter logic [6:0]  CHECK_MASK    = 7'h7F
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [6:0]       gate_y,
    output logic             a_out,
    output logic             b_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_cnt,
    output logic [3:0]       fail_vec
);

    localparam int unsigned CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES + 1) : 1;
    localparam int unsigned SUM_W = ((ERR_W > 3) ? ERR_W : 3) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_CHECK,
        S_DONE
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] settle_cnt;
    logic [1:0]       idx;
    logic [6:0]       golden;
    logic [6:0]       mism;
    logic [2:0]       mism_pop;
    logic [SUM_W-1:0] err_sum;
    logic [ERR_W-1:0] err_nxt;

    // The vector index is exactly the driven stimulus, so no separate register is kept.
    assign idx = {a_out, b_out};

    always_comb begin
        golden = {idx[1] & idx[0], idx[1] | idx[0], ~idx[1], ~(idx[1] & idx[0]),
                  ~(idx[1] | idx[0]), idx[1] ^ idx[0], ~(idx[1] ^ idx[0])};
        mism   = (gate_y ^ golden) & CHECK_MASK;
    end

    always_comb begin
        mism_pop = '0;
        for (int unsigned i = 0; i < 7; i++) begin
            mism_pop = mism_pop + {2'b00, mism[i]};
        end
    end

    always_comb begin
        err_sum = SUM_W'(err_cnt) + SUM_W'(mism_pop);
        if (err_sum > SUM_W'({ERR_W{1'b1}})) begin
            err_nxt = '1;
        end else begin
            err_nxt = err_sum[ERR_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (start) state_nxt = S_SETTLE;
            S_SETTLE: if (settle_cnt == CNT_W'(1)) state_nxt = S_CHECK;
            S_CHECK:  state_nxt = (idx == 2'b11) ? S_DONE : S_SETTLE;
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state == S_SETTLE) || (state == S_CHECK);
        done = (state == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            settle_cnt <= '0;
            a_out      <= 1'b0;
            b_out      <= 1'b0;
            err_cnt    <= '0;
            fail_vec   <= '0;
            pass       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        settle_cnt <= CNT_W'(SETTLE_CYCLES);
                        a_out      <= 1'b0;
                        b_out      <= 1'b0;
                        err_cnt    <= '0;
                        fail_vec   <= '0;
                        pass       <= 1'b0;
                    end
                end
                S_SETTLE: begin
                    if (settle_cnt != CNT_W'(1)) begin
                        settle_cnt <= settle_cnt - CNT_W'(1);
                    end
                end
                S_CHECK: begin
                    err_cnt       <= err_nxt;
                    fail_vec[idx] <= |mism;
                    if (idx != 2'b11) begin
                        {a_out, b_out} <= idx + 2'b01;
                        settle_cnt     <= CNT_W'(SETTLE_CYCLES);
                    end else begin
                        // pass is registered on entry to DONE so it is valid alongside done.
                        pass <= (err_nxt == '0);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_gate_stim_checker.sv
// Scoreboarded bench: three checker instances (default, reduced mask, narrow
// error counter) each watch their own model gate bank with injected faults.
module tb_gate_stim_checker;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic [27:0] corrupt;

    logic       a0, b0, busy0, done0, pass0;
    logic [4:0] err0;
    logic [3:0] fv0;
    logic [6:0] gy0;
    logic       a1, b1, busy1, done1, pass1;
    logic [4:0] err1;
    logic [3:0] fv1;
    logic [6:0] gy1;
    logic       a2, b2, busy2, done2, pass2;
    logic [2:0] err2;
    logic [3:0] fv2;
    logic [6:0] gy2;

    int n_chk  = 0;
    int n_fail = 0;
    int n_done0 = 0;

    logic [9:0] q0[$];
    logic [9:0] q1[$];
    logic [9:0] q2[$];

    always #5 clk = ~clk;

    // Model gate bank: correct gates, XORed with a per-vector fault pattern.
    function automatic logic [6:0] bank(input logic a, input logic b, input logic [27:0] c);
        int v;
        logic [6:0] g;
        v = {30'd0, a, b};
        g = {a & b, a | b, ~a, ~(a & b), ~(a | b), a ^ b, ~(a ^ b)};
        return g ^ c[v*7 +: 7];
    endfunction

    // Expected {pass, err_cnt, fail_vec}: mismatches are exactly the masked fault bits.
    function automatic logic [9:0] expect_of(input logic [27:0] c, input logic [6:0] m,
                                             input int unsigned w);
        int unsigned tot;
        int unsigned cap;
        int unsigned n;
        logic [3:0] fv;
        tot = 0;
        fv  = '0;
        cap = (1 << w) - 1;
        for (int v = 0; v < 4; v++) begin
            n = $countones(c[v*7 +: 7] & m);
            tot += n;
            fv[v] = (n != 0);
        end
        if (tot > cap) tot = cap;
        return {(tot == 0), tot[4:0], fv};
    endfunction

    assign gy0 = bank(a0, b0, corrupt);
    assign gy1 = bank(a1, b1, corrupt);
    assign gy2 = bank(a2, b2, corrupt);

    gate_stim_checker dut0 (
        .clk(clk), .rst(rst), .start(start), .gate_y(gy0),
        .a_out(a0), .b_out(b0), .busy(busy0), .done(done0), .pass(pass0),
        .err_cnt(err0), .fail_vec(fv0)
    );

    gate_stim_checker #(.CHECK_MASK(7'h3F)) dut1 (
        .clk(clk), .rst(rst), .start(start), .gate_y(gy1),
        .a_out(a1), .b_out(b1), .busy(busy1), .done(done1), .pass(pass1),
        .err_cnt(err1), .fail_vec(fv1)
    );

    gate_stim_checker #(.ERR_W(3)) dut2 (
        .clk(clk), .rst(rst), .start(start), .gate_y(gy2),
        .a_out(a2), .b_out(b2), .busy(busy2), .done(done2), .pass(pass2),
        .err_cnt(err2), .fail_vec(fv2)
    );

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%h expected=%h at %0t", nm, got, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (done0) begin
            n_done0++;
            if (q0.size() == 0) check("dut0_unexpected_done", 1, 0);
            else check("dut0_result", {pass0, err0, fv0}, q0.pop_front());
        end
    end

    always @(posedge clk) begin
        #1;
        if (done1) begin
            if (q1.size() == 0) check("dut1_unexpected_done", 1, 0);
            else check("dut1_mask3f_result", {pass1, err1, fv1}, q1.pop_front());
        end
    end

    always @(posedge clk) begin
        #1;
        if (done2) begin
            if (q2.size() == 0) check("dut2_unexpected_done", 1, 0);
            else check("dut2_errw3_result", {pass2, 2'b00, err2, fv2}, q2.pop_front());
        end
    end

    task automatic push_expect(input logic [27:0] c);
        q0.push_back(expect_of(c, 7'h7F, 5));
        q1.push_back(expect_of(c, 7'h3F, 5));
        q2.push_back(expect_of(c, 7'h7F, 3));
    endtask

    task automatic run(input logic [27:0] c);
        logic seen;
        @(negedge clk);
        corrupt = c;
        push_expect(c);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(posedge clk);
            #1;
            if (done0) seen = 1'b1;
        end
        check("done_seen", {31'd0, seen}, 1);
        @(posedge clk);
        #1;
        check("done_one_cycle", {31'd0, done0}, 0);
    endtask

    task automatic run_timed();
        @(negedge clk);
        corrupt = '0;
        push_expect('0);
        start = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            @(posedge clk);
            #1;
            if (c == 1) start = 1'b0;
            check($sformatf("busy_c%0d", c), {31'd0, busy0}, (c <= 8) ? 1 : 0);
            check($sformatf("done_c%0d", c), {31'd0, done0}, (c == 9) ? 1 : 0);
            if (c <= 8) check($sformatf("ab_c%0d", c), {30'd0, a0, b0}, (c - 1) / 2);
        end
        @(posedge clk);
        #1;
        check("done_after", {31'd0, done0}, 0);
    endtask

    task automatic check_reset_vals(input string nm);
        check({nm, "_ab"}, {30'd0, a0, b0}, 0);
        check({nm, "_busy_done_pass"}, {29'd0, busy0, done0, pass0}, 0);
        check({nm, "_err"}, {27'd0, err0}, 0);
        check({nm, "_fv"}, {28'd0, fv0}, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int dones_before;
        logic [27:0] r;
        rst = 1'b1;
        start = 1'b0;
        corrupt = '0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_vals("reset");
        @(negedge clk);
        rst = 1'b0;

        run_timed();
        check("golden_pass", {31'd0, pass0}, 1);

        run(28'h1 << 27);
        run({4{7'b0000010}});
        run('1);

        // start held through a run, reset lands mid-run together with start high
        @(negedge clk);
        corrupt = '0;
        push_expect('0);
        start = 1'b1;
        dones_before = n_done0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        q0.delete();
        q1.delete();
        q2.delete();
        @(posedge clk);
        #1;
        check_reset_vals("midrun_rst");
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("no_done_after_rst", n_done0, dones_before);
        check("idle_after_rst", {31'd0, busy0}, 0);
        run('0);
        check("fresh_run_pass", {31'd0, pass0}, 1);

        for (int k = 0; k < 10; k++) begin
            case (k % 3)
                0: r = 28'($urandom);
                1: r = 28'($urandom & $urandom & $urandom);
                default: r = 28'($urandom & $urandom & $urandom & $urandom & $urandom);
            endcase
            run(r);
        end

        repeat (2) @(posedge clk);
        #1;
        check("scoreboard_drained", q0.size() + q1.size() + q2.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
